// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state type and default widths for the timer_ctrl block.
package timer_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_PRE_W = 4;
endpackage

// File: rtl/timer_prescale.sv
// timer_prescale: clock-enable divider; en pulses once every div+1 clocks, restarting on clr.
module timer_prescale
    import timer_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [PRE_W-1:0] div,
    output logic             en
);
    logic [PRE_W-1:0] cnt_q, cnt_d;
    assign en = !clr && (cnt_q == div);
    always_comb cnt_d = (clr || en) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: one-shot/periodic terminal-count timer with start/stop control.
// Define TIMER_PRESCALE_EN to add the prescale port and clock-enable divider.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] period,
`ifdef TIMER_PRESCALE_EN
    input  logic [PRE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, period_q, period_d;
    logic             periodic_q, periodic_d, tick_q, tick_d, done_q, done_d;
    logic             en, accept;
    logic [PRE_W-1:0] prescale_q;

    assign accept = (state_q == IDLE) && start && !stop && (period != '0);

`ifdef TIMER_PRESCALE_EN
    logic [PRE_W-1:0] prescale_d;
    assign prescale_d = accept ? prescale : prescale_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prescale_q <= '0;
        else          prescale_q <= prescale_d;
    end
    // Held clear outside RUN so the first enable lands prescale_q+1 clocks after accept.
    timer_prescale #(.PRE_W(PRE_W)) u_prescale (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     ((state_q != RUN) || stop),
        .div     (prescale_q),
        .en      (en)
    );
`else
    assign prescale_q = '0;
    assign en = (prescale_q == '0);
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (accept) begin
                    state_d    = RUN;
                    period_d   = period;
                    periodic_d = periodic;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (en) begin
                    if (count_q == period_q) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        state_d = periodic_q ? RUN : IDLE;
                        done_d  = !periodic_q;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tick  = tick_q;
    assign done  = done_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed stimulus pushes per-cycle expectations; a single monitor pops and compares.
module tb_timer_ctrl;
    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0;
    logic [7:0] period = '0;
`ifdef TIMER_PRESCALE_EN
    logic [3:0] prescale = '0;
`endif
    logic [7:0] count;
    logic       busy, tick, done;

    typedef struct {
        int         c;
        logic [7:0] cnt;
        logic       b, t, d;
    } exp_t;

    exp_t q[$], aq[$];
    exp_t e;
    int   cyc = 0, errors = 0, checks = 0;
    bit   fin = 1'b0;
    int   a, m;
    event chk_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
`ifdef TIMER_PRESCALE_EN
        .prescale (prescale),
`endif
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    task automatic push(input int c, input logic [7:0] cnt, input logic b, input logic t, input logic d);
        q.push_back('{c, cnt, b, t, d});
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic launch(input logic [7:0] p, input logic md);
        start = 1'b1; period = p; periodic = md;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sole owner of the check counters: async checks, per-cycle checks, end and watchdog.
    initial forever begin
        @(negedge clk or chk_ev);
        while (aq.size() > 0) begin
            e = aq.pop_front();
            checks++;
            if ({count, busy, tick, done} !== {e.cnt, e.b, e.t, e.d}) begin
                errors++;
                $display("FAIL async_reset: got count=%0d busy=%b tick=%b done=%b, want count=%0d busy=%b tick=%b done=%b",
                         count, busy, tick, done, e.cnt, e.b, e.t, e.d);
            end
        end
        while (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.c != cyc || {count, busy, tick, done} !== {e.cnt, e.b, e.t, e.d}) begin
                errors++;
                $display("FAIL cycle_%0d (at %0d): got count=%0d busy=%b tick=%b done=%b, want count=%0d busy=%b tick=%b done=%b",
                         e.c, cyc, count, busy, tick, done, e.cnt, e.b, e.t, e.d);
            end
        end
        if (fin || cyc > 3000) begin
            if (q.size() > 0 || !fin) begin
                checks++;
                errors++;
                $display("FAIL timeout: %0d expectations pending, stimulus finished=%0b", q.size(), fin);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #1;
        aq.push_back('{0, 8'd0, 1'b0, 1'b0, 1'b0});
        ->chk_ev;
        #9 reset_n = 1'b1;
        @(negedge clk);
        push(cyc + 1, 8'd0, 1'b0, 1'b0, 1'b0);
        push(cyc + 2, 8'd0, 1'b0, 1'b0, 1'b0);
        goto(cyc + 2);

        // one-shot period 3
        a = cyc + 1;
        for (int k = 0; k <= 5; k++) push(a + k, (k < 4) ? 8'(k) : 8'd0, k < 4, k == 4, k == 4);
        launch(8'd3, 1'b0);
        goto(a + 5);

        // start together with stop in IDLE
        a = cyc + 1;
        push(a, 8'd0, 1'b0, 1'b0, 1'b0);
        push(a + 1, 8'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; stop = 1'b1; period = 8'd5;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        goto(a + 1);

        // periodic period 2, ignored restart mid-run, then stop
        a = cyc + 1;
        for (int k = 0; k <= 12; k++) push(a + k, 8'(k % 3), 1'b1, k > 0 && (k % 3) == 0, 1'b0);
        push(a + 13, 8'd0, 1'b0, 1'b0, 1'b0);
        launch(8'd2, 1'b1);
        goto(a + 4);
        start = 1'b1; period = 8'd7; periodic = 1'b0;
        @(negedge clk);
        start = 1'b0;
        goto(a + 12);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        goto(a + 14);

        // periodic period 5, stop on the terminal-count cycle
        a = cyc + 1;
        for (int k = 0; k <= 5; k++) push(a + k, 8'(k), 1'b1, 1'b0, 1'b0);
        push(a + 6, 8'd0, 1'b0, 1'b0, 1'b0);
        push(a + 7, 8'd0, 1'b0, 1'b0, 1'b0);
        launch(8'd5, 1'b1);
        goto(a + 5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        goto(a + 7);

        // period 0 start is ignored
        a = cyc + 1;
        push(a, 8'd0, 1'b0, 1'b0, 1'b0);
        push(a + 1, 8'd0, 1'b0, 1'b0, 1'b0);
        launch(8'd0, 1'b1);
        goto(a + 1);

        // one-shot period 10, reset at count 4, then a full run
        a = cyc + 1;
        for (int k = 0; k <= 4; k++) push(a + k, 8'(k), 1'b1, 1'b0, 1'b0);
        launch(8'd10, 1'b0);
        goto(a + 4);
        #1 reset_n = 1'b0;
        #1 aq.push_back('{0, 8'd0, 1'b0, 1'b0, 1'b0});
        ->chk_ev;
        @(negedge clk);
        reset_n = 1'b1;
        m = cyc;
        push(m + 1, 8'd0, 1'b0, 1'b0, 1'b0);
        push(m + 2, 8'd0, 1'b0, 1'b0, 1'b0);
        goto(m + 2);
        a = cyc + 1;
        for (int k = 0; k <= 11; k++) push(a + k, (k < 11) ? 8'(k) : 8'd0, k < 11, k == 11, k == 11);
        launch(8'd10, 1'b0);
        goto(a + 12);

        // maximum period: 256 enable cycles per tick
        a = cyc + 1;
        for (int k = 0; k <= 256; k++) push(a + k, (k < 256) ? 8'(k) : 8'd0, k < 256, k == 256, k == 256);
        launch(8'd255, 1'b0);
        goto(a + 257);

`ifdef TIMER_PRESCALE_EN
        // prescale 2, period 1: count steps every 3 clocks, tick 6 clocks after accept
        prescale = 4'd2;
        a = cyc + 1;
        for (int k = 0; k <= 7; k++) push(a + k, (k < 6) ? 8'(k / 3) : 8'd0, k < 6, k == 6, k == 6);
        launch(8'd1, 1'b0);
        goto(a + 7);
        prescale = 4'd0;
`endif
        fin = 1'b1;
    end
endmodule
